// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/full_adder_struct.sv
// Structural full adder: two half adders whose carries are merged by an OR gate.
module full_adder_struct (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  // first half adder: a + b
  xor u_x1 (hs1, a, b);
  and u_a1 (hc1, a, b);
  // second half adder: partial sum + carry-in
  xor u_x2 (s, hs1, ci);
  and u_a2 (hc2, hs1, ci);
  or  u_o1 (co, hc1, hc2);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with start/busy/done handshake, one bit per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a Sub input that turns the block into A-B (two's complement).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  full_adder_struct u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Subtraction is A + ~B + 1, so only the operand/carry load changes.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = Sub ? ~B : B;
  assign c_load = Sub ? 1'b1 : Cin;
`else
  assign b_load = B;
  assign c_load = Cin;
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {fa_s, res_q[WIDTH-1:1]};
        c_d    = fa_co;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed handshake cases plus random operands against
// an arithmetic reference ({Cout,Sum} = A + B + Cin, or A + ~B + 1 when subtracting).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic [W-1:0] exp_sum;
  logic         exp_cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub   (Sub),
`endif
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference for one operation.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sub);
    logic [W:0] r;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
`else
    r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
`endif
    exp_sum  = r[W-1:0];
    exp_cout = r[W];
  endtask

  // Present operands with start for one edge; operands are scrambled afterwards.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sub);
    A = a; B = b; Cin = ci; Sub = sub; start = 1'b1;
    model(a, b, ci, sub);
    step();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
    chk("launch_busy", 32'(busy), 32'd1);
    chk("launch_done", 32'(done), 32'd0);
    chk("launch_sum_held", 32'(Sum), 32'(prev_sum));
  endtask

  // Walk the remaining WIDTH edges; optionally pulse a stray start at cycle ign_at.
  task automatic finish(input int ign_at);
    for (int j = 1; j <= W; j++) begin
      step();
      start = 1'b0;
      if (j < W) begin
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_done", 32'(done), 32'd0);
        chk("run_sum_held", 32'(Sum), 32'(prev_sum));
        chk("run_cout_held", 32'(Cout), 32'(prev_cout));
        if (j == ign_at) begin
          A = 8'h01; B = 8'h01; Cin = 1'b0; start = 1'b1;
        end
      end else begin
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_sum", 32'(Sum), 32'(exp_sum));
        chk("end_cout", 32'(Cout), 32'(exp_cout));
      end
    end
    prev_sum  = exp_sum;
    prev_cout = exp_cout;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sub);
    launch(a, b, ci, sub);
    finish(0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed sums.
    run_op(8'h5A, 8'h33, 1'b0, 1'b0);
    chk("5A+33_sum", 32'(Sum), 32'h8D);
    step();
    chk("idle_after_done", 32'(done), 32'd0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    chk("FF+01_cout", 32'(Cout), 32'd1);
    step();
    run_op(8'hFF, 8'h00, 1'b1, 1'b0);
    chk("FF+00+1_sum", 32'(Sum), 32'h00);
    step();

    // Stray start mid-operation is ignored.
    launch(8'h10, 8'h20, 1'b0, 1'b0);
    finish(2);
    chk("ign_sum", 32'(Sum), 32'h30);
    step();
    chk("ign_single_done", 32'(done), 32'd0);
    chk("ign_not_busy", 32'(busy), 32'd0);
    chk("ign_sum_kept", 32'(Sum), 32'h30);

    // Back-to-back: second start in the done cycle of the first.
    run_op(8'h40, 8'h05, 1'b1, 1'b0);
    launch(8'h01, 8'h02, 1'b0, 1'b0);
    finish(0);
    chk("b2b_sum", 32'(Sum), 32'h03);
    step();

    // Reset in the middle of an operation clears everything at once.
    launch(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(Sum), 32'd0);
    chk("mid_rst_cout", 32'(Cout), 32'd0);
    step();
    rst_n = 1'b1;
    prev_sum = '0; prev_cout = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      step();
      chk("post_rst_no_done", 32'(done), 32'd0);
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1);
    chk("sub_10_01_sum", 32'(Sum), 32'h0F);
    chk("sub_10_01_cout", 32'(Cout), 32'd1);
    run_op(8'h00, 8'h01, 1'b1, 1'b1);
    chk("sub_00_01_sum", 32'(Sum), 32'hFF);
    chk("sub_00_01_cout", 32'(Cout), 32'd0);
`endif

    // Random operations, some back-to-back, some with idle gaps.
    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        step();
        chk("rand_gap_done", 32'(done), 32'd0);
      end
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
